// File: rtl/fnd_pkg.sv
/*----------------------------------------------------------------------
 * fnd_pkg : 7-segment codes, digit codes and FSM encoding for fnd_scan_rx
 * Rev 1.0
 *--------------------------------------------------------------------*/
`default_nettype none

package fnd_pkg;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR   = 4'hE;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  // Blank and error codes count as zero in the arithmetic.
  function automatic logic [5:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [3:0] t;
    logic [3:0] o;
    t = (tens > 4'd9) ? 4'd0 : tens;
    o = (ones > 4'd9) ? 4'd0 : ones;
    return 6'(32'(t) * 10 + 32'(o));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fnd_enc.sv
/*----------------------------------------------------------------------
 * fnd_enc : inverse 7-segment decoder (exact match, error flag)
 * Rev 1.0
 *--------------------------------------------------------------------*/
`default_nettype none

module fnd_enc
  import fnd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] dig,
  output logic       err
);

  always_comb begin
    dig = DIG_ERR;
    err = 1'b0;
    case (seg)
      SEG_0:     dig = 4'd0;
      SEG_1:     dig = 4'd1;
      SEG_2:     dig = 4'd2;
      SEG_3:     dig = 4'd3;
      SEG_4:     dig = 4'd4;
      SEG_5:     dig = 4'd5;
      SEG_6:     dig = 4'd6;
      SEG_7:     dig = 4'd7;
      SEG_8:     dig = 4'd8;
      SEG_9:     dig = 4'd9;
      SEG_BLANK: dig = DIG_BLANK;
      default: begin
        dig = DIG_ERR;
        err = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fnd_scan_rx.sv
/*----------------------------------------------------------------------
 * fnd_scan_rx : six-digit multiplexed 7-segment bus receiver -> HH:MM:SS
 * Rev 1.0
 *--------------------------------------------------------------------*/
`default_nettype none

module fnd_scan_rx
  import fnd_pkg::*;
#(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic [5:0]  o_hou,
  output logic [5:0]  o_min,
  output logic [5:0]  o_sec,
  output logic        o_frame_vld,
  output logic        o_time_vld,
  output logic        o_seg_err,
  output logic        o_seq_err,
  output logic        o_link_ok
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [6:0]    seg_q;
  logic          dp_q;
  logic [5:0]    enb_q, enb_prev;
  logic [7:0]    settle_cnt;
  logic [TW-1:0] to_cnt;
  state_t        state, state_nxt;
  logic [2:0]    expect_idx, expect_nxt;
  logic [23:0]   shadow_dig;
  logic [5:0]    shadow_dp;

  logic       settle_clr, cap, to_hit, store, seq_err_nxt;
  logic [2:0] idx;
  logic [3:0] enc_dig;
  logic       enc_err;
  logic [5:0] hou_c, min_c, sec_c;
  logic       frame_ok, tv_c;

  fnd_enc u_enc (
    .seg (seg_q),
    .dig (enc_dig),
    .err (enc_err)
  );

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (!enb_q[i]) idx = 3'(i);
    end
  end

  assign settle_clr = (enb_q != enb_prev) || ($countones(~enb_q) != 1);
  // The timeout is re-armed by every capture, so it only has to outlast one slot.
  assign to_hit = (to_cnt == TW'(TIMEOUT_CYC - 1)) && (state != COMMIT);
  assign cap    = !settle_clr && (settle_cnt == 8'(SETTLE_CYC - 1)) && !to_hit;

  always_comb begin
    state_nxt   = state;
    expect_nxt  = expect_idx;
    store       = 1'b0;
    seq_err_nxt = 1'b0;
    case (state)
      HUNT: begin
        if (cap && idx == 3'd0) begin
          store      = 1'b1;
          expect_nxt = 3'd1;
          state_nxt  = COLLECT;
        end
      end
      COLLECT: begin
        if (cap) begin
          if (idx == expect_idx) begin
            store = 1'b1;
            if (expect_idx == 3'd5) state_nxt = COMMIT;
            else                    expect_nxt = expect_idx + 3'd1;
          end else begin
            seq_err_nxt = 1'b1;
            if (idx == 3'd0) begin
              store      = 1'b1;
              expect_nxt = 3'd1;
            end else begin
              state_nxt = HUNT;
            end
          end
        end
      end
      COMMIT:  state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
    if (to_hit) state_nxt = HUNT;
  end

  always_comb begin
    hou_c    = bcd2bin(shadow_dig[23:20], shadow_dig[19:16]);
    min_c    = bcd2bin(shadow_dig[15:12], shadow_dig[11:8]);
    sec_c    = bcd2bin(shadow_dig[7:4],   shadow_dig[3:0]);
    frame_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (shadow_dig[4*i +: 4] == DIG_ERR) frame_ok = 1'b0;
      if (i < 5 && shadow_dig[4*i +: 4] == DIG_BLANK) frame_ok = 1'b0;
    end
    tv_c = frame_ok && (hou_c <= 6'd23) && (min_c <= 6'd59) && (sec_c <= 6'd59);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= '0;
      dp_q       <= 1'b0;
      enb_q      <= '1;
      enb_prev   <= '1;
      settle_cnt <= '0;
      to_cnt     <= '0;
      state      <= HUNT;
      expect_idx <= '0;
      shadow_dig <= '0;
      shadow_dp  <= '0;
    end else begin
      seg_q    <= i_seg;
      dp_q     <= i_seg_dp;
      enb_q    <= i_seg_enb;
      enb_prev <= enb_q;
      if (settle_clr)              settle_cnt <= '0;
      else if (settle_cnt != 8'hFF) settle_cnt <= settle_cnt + 8'd1;
      if (cap || state == COMMIT)            to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYC))   to_cnt <= to_cnt + 1'b1;
      state      <= state_nxt;
      expect_idx <= expect_nxt;
      if (store) begin
        shadow_dig[4*idx +: 4] <= enc_dig;
        shadow_dp[idx]         <= dp_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_digits    <= '0;
      o_dp        <= '0;
      o_hou       <= '0;
      o_min       <= '0;
      o_sec       <= '0;
      o_frame_vld <= 1'b0;
      o_time_vld  <= 1'b0;
      o_seg_err   <= 1'b0;
      o_seq_err   <= 1'b0;
      o_link_ok   <= 1'b0;
    end else begin
      o_frame_vld <= 1'b0;
      o_seg_err   <= cap && enc_err;
      o_seq_err   <= seq_err_nxt;
      if (state == COMMIT) begin
        o_digits    <= shadow_dig;
        o_dp        <= shadow_dp;
        o_hou       <= hou_c;
        o_min       <= min_c;
        o_sec       <= sec_c;
        o_time_vld  <= tv_c;
        o_frame_vld <= 1'b1;
        o_link_ok   <= 1'b1;
      end
      if (to_hit) begin
        o_link_ok  <= 1'b0;
        o_time_vld <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fnd_scan_rx.sv
/*----------------------------------------------------------------------
 * tb_fnd_scan_rx : directed + randomized bench for fnd_scan_rx
 * Rev 1.0
 *--------------------------------------------------------------------*/
`default_nettype none
`timescale 1ns/1ps

module tb_fnd_scan_rx;

  localparam int SETTLE = 4;
  localparam int TMO    = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = '0;
  logic        seg_dp = 1'b0;
  logic [5:0]  seg_enb = '1;
  logic [23:0] digits;
  logic [5:0]  dp, hou, min, sec;
  logic        frame_vld, time_vld, seg_err, seq_err, link_ok;

  fnd_scan_rx #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_seg(seg), .i_seg_dp(seg_dp), .i_seg_enb(seg_enb),
    .o_digits(digits), .o_dp(dp), .o_hou(hou), .o_min(min), .o_sec(sec),
    .o_frame_vld(frame_vld), .o_time_vld(time_vld),
    .o_seg_err(seg_err), .o_seq_err(seq_err), .o_link_ok(link_ok)
  );

  always #10 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int frames = 0, seg_errs = 0, seq_errs = 0;
  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h73};

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_vld) frames++;
      if (seg_err)   seg_errs++;
      if (seq_err)   seq_errs++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d, input logic [6:0] bad);
    if (d < 4'd10)      return seg_tab[d];
    else if (d == 4'hF) return 7'h00;
    else                return bad;
  endfunction

  function automatic logic [6:0] rand_bad();
    logic [6:0] p;
    bit ok;
    do begin
      p  = 7'($urandom);
      ok = (p != 7'h00);
      for (int k = 0; k < 10; k++) if (seg_tab[k] == p) ok = 0;
    end while (!ok);
    return p;
  endfunction

  // Reference: value rules of the frame, straight from decimal arithmetic.
  function automatic int num(input logic [3:0] d);
    return (d < 4'd10) ? int'(d) : 0;
  endfunction

  function automatic logic [18:0] model(input logic [23:0] d);
    int h, m, s;
    bit ok;
    h = (num(d[23:20]) * 10 + num(d[19:16])) % 64;
    m = (num(d[15:12]) * 10 + num(d[11:8]))  % 64;
    s = (num(d[7:4])   * 10 + num(d[3:0]))   % 64;
    ok = (h <= 23) && (m <= 59) && (s <= 59);
    for (int k = 0; k < 6; k++) begin
      if (d[4*k +: 4] == 4'hE) ok = 0;
      if (k < 5 && d[4*k +: 4] == 4'hF) ok = 0;
    end
    return {ok, 6'(h), 6'(m), 6'(s)};
  endfunction

  task automatic hold(input logic [5:0] e, input logic [6:0] s, input logic d, input int len);
    seg_enb = e; seg = s; seg_dp = d;
    repeat (len) @(negedge clk);
  endtask

  task automatic slot(input int idx, input logic [6:0] s, input logic d, input int len);
    logic [5:0] e;
    e = 6'b1 << idx;
    hold(~e, s, d, len);
    hold(6'h3F, 7'h00, 1'b0, 1);
  endtask

  task automatic glitch();
    logic [5:0] e;
    e = 6'b1 << $urandom_range(0, 5);
    if ($urandom_range(0, 1) == 0) e = 6'b000011;
    hold(~e, 7'($urandom), 1'b0, 2);
    hold(6'h3F, 7'h00, 1'b0, 1);
  endtask

  task automatic send_frame(input logic [23:0] d, input logic [5:0] dps, input logic [6:0] bad,
                            input bit glitches);
    for (int i = 0; i < 6; i++) begin
      if (glitches) glitch();
      slot(i, seg_of(d[4*i +: 4], bad), dps[i], $urandom_range(SETTLE + 4, 40));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_check(input string tag, input logic [23:0] d, input logic [5:0] dps,
                             input logic [6:0] bad, input bit glitches);
    int f0, e0, q0, n_e;
    logic [18:0] m;
    f0 = frames; e0 = seg_errs; q0 = seq_errs; n_e = 0;
    for (int k = 0; k < 6; k++) if (d[4*k +: 4] == 4'hE) n_e++;
    m = model(d);
    send_frame(d, dps, bad, glitches);
    chk({tag, ".frames"},  32'(frames - f0), 32'd1);
    chk({tag, ".digits"},  32'(digits), 32'(d));
    chk({tag, ".dp"},      32'(dp), 32'(dps));
    chk({tag, ".hou"},     32'(hou), 32'(m[17:12]));
    chk({tag, ".min"},     32'(min), 32'(m[11:6]));
    chk({tag, ".sec"},     32'(sec), 32'(m[5:0]));
    chk({tag, ".tvld"},    32'(time_vld), 32'(m[18]));
    chk({tag, ".link"},    32'(link_ok), 32'd1);
    chk({tag, ".segerr"},  32'(seg_errs - e0), 32'(n_e));
    chk({tag, ".seqerr"},  32'(seq_errs - q0), 32'd0);
  endtask

  initial begin
    int f0, q0;
    logic [23:0] rd;
    repeat (4) @(negedge clk);
    chk("rst.digits", 32'(digits), 0);
    chk("rst.dp",     32'(dp), 0);
    chk("rst.hms",    32'({hou, min, sec}), 0);
    chk("rst.pulses", 32'({frame_vld, seg_err, seq_err}), 0);
    chk("rst.tvld",   32'(time_vld), 0);
    chk("rst.link",   32'(link_ok), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    frame_check("f123456", 24'h123456, 6'b000100, 7'h01, 0);
    frame_check("glitch",  24'h123456, 6'b010100, 7'h01, 1);

    f0 = frames; q0 = seq_errs;
    slot(0, seg_tab[1], 1'b0, 20);
    slot(1, seg_tab[2], 1'b0, 20);
    slot(3, seg_tab[3], 1'b0, 20);
    repeat (3) @(negedge clk);
    chk("order.seqerr", 32'(seq_errs - q0), 32'd1);
    chk("order.noframe", 32'(frames - f0), 32'd0);
    frame_check("after_order", 24'h083015, 6'b000000, 7'h01, 0);

    frame_check("segerr", 24'h123E56, 6'b000000, 7'h01, 0);
    chk("segerr.nibble", 32'(digits[11:8]), 32'hE);
    frame_check("f256100", 24'h256100, 6'b000000, 7'h01, 0);
    frame_check("blank5",  24'hF93059, 6'b000000, 7'h01, 0);

    for (int n = 0; n < 8; n++) begin
      rd = '0;
      for (int k = 0; k < 6; k++) begin
        int r;
        r = $urandom_range(0, 22);
        rd[4*k +: 4] = (r < 20) ? 4'(r % 10) : (r == 20) ? 4'hF : 4'hE;
      end
      frame_check("rand", rd, 6'($urandom), rand_bad(), bit'($urandom_range(0, 1)));
    end

    frame_check("pre_tmo", 24'h235959, 6'b000000, 7'h01, 0);
    hold(6'h3F, 7'h00, 1'b0, TMO - 100);
    chk("tmo.link_before", 32'(link_ok), 1);
    hold(6'h3F, 7'h00, 1'b0, 200);
    chk("tmo.link_after", 32'(link_ok), 0);
    chk("tmo.tvld_after", 32'(time_vld), 0);
    chk("tmo.digits_kept", 32'(digits), 32'h235959);

    frame_check("relink", 24'h000001, 6'b000000, 7'h01, 0);
    slot(0, seg_tab[4], 1'b1, 20);
    slot(1, seg_tab[4], 1'b1, 20);
    seg_enb = 6'b111011; seg = seg_tab[4];
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.digits", 32'(digits), 0);
    chk("arst.hms",    32'({hou, min, sec}), 0);
    chk("arst.flags",  32'({frame_vld, time_vld, seg_err, seq_err, link_ok, dp}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    f0 = frames;
    for (int i = 2; i < 6; i++) slot(i, seg_tab[i], 1'b0, 20);
    repeat (3) @(negedge clk);
    chk("arst.nopartial", 32'(frames - f0), 0);
    chk("arst.digits0",   32'(digits), 0);
    frame_check("post_rst", 24'h102030, 6'b100001, 7'h01, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
